// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75E frame-buffer slice: panel geometry,
// pixel width and the bank-swap state encoding.
package hub75_pkg;

   localparam int unsigned ROW_BITS  = 5;
   localparam int unsigned COL_BITS  = 6;
   localparam int unsigned ADDR_BITS = ROW_BITS + COL_BITS;
   localparam int unsigned PIX_BITS  = 15;

   // Bank-swap controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_SWAP = 2'd2
   } swap_state_t;

endpackage

// File: rtl/hub75_wr_fifo.sv
// Posted-write FIFO holding {addr, data} host writes until the scanner
// leaves a RAM cycle free. Head entry is presented combinationally.
module hub75_wr_fifo #(
   parameter int unsigned AW    = 11,
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       CLK_IN,
   input  logic                       resetn,
   input  logic                       push_i,
   input  logic [AW-1:0]              push_addr_i,
   input  logic [DW-1:0]              push_data_i,
   input  logic                       pop_i,
   output logic [AW-1:0]              head_addr_o,
   output logic [DW-1:0]              head_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [AW-1:0] addr_mem_q [DEPTH];
   logic [DW-1:0] data_mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   level_q,  level_d;
   logic          do_push, do_pop;

   assign full_o      = (level_q == (PW+1)'(DEPTH));
   assign empty_o     = (level_q == '0);
   assign level_o     = level_q;
   assign head_addr_o = addr_mem_q[rd_ptr_q];
   assign head_data_o = data_mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i  && !empty_o;

   // Next pointer and occupancy; simultaneous push and pop keep the level
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Pointer/level registers; reset discards any queued entries
   always_ff @(posedge CLK_IN) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Entry storage, no reset needed since the level gates visibility
   always_ff @(posedge CLK_IN) begin
      if (do_push) begin
         addr_mem_q[wr_ptr_q] <= push_addr_i;
         data_mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/hub75_fb_arbiter.sv
// Double-buffered frame-buffer arbiter: scanner reads the front bank with
// strict priority, host writes drain to the back bank in idle cycles, and
// banks swap on request at the next frame boundary with the FIFO empty.
module hub75_fb_arbiter #(
   parameter int unsigned ADDR_BITS  = hub75_pkg::ADDR_BITS,
   parameter int unsigned DATA_BITS  = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          CLK_IN,
   input  logic                          resetn,
   input  logic                          scan_req,
   input  logic [ADDR_BITS-1:0]          scan_addr,
   output logic [DATA_BITS-1:0]          scan_rdata,
   output logic                          scan_rvalid,
   input  logic                          frame_end,
   input  logic                          host_wvalid,
   output logic                          host_wready,
   input  logic [ADDR_BITS-1:0]          host_waddr,
   input  logic [DATA_BITS-1:0]          host_wdata,
   input  logic                          swap_req,
   output logic                          swap_done,
   output logic                          front_bank,
   output logic [$clog2(FIFO_DEPTH):0]   wr_level,
   output logic                          ram_ce,
   output logic                          ram_we,
   output logic [ADDR_BITS:0]            ram_addr,
   output logic [DATA_BITS-1:0]          ram_wdata,
   input  logic [DATA_BITS-1:0]          ram_rdata
);

   import hub75_pkg::*;

   swap_state_t          state_q, state_d;
   logic                 front_bank_q, front_bank_d;
   logic                 scan_rvalid_q;

   logic                 fifo_push, fifo_pop;
   logic                 fifo_full, fifo_empty;
   logic [ADDR_BITS-1:0] head_addr;
   logic [DATA_BITS-1:0] head_data;

   hub75_wr_fifo #(
      .AW    (ADDR_BITS),
      .DW    (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .CLK_IN      (CLK_IN),
      .resetn      (resetn),
      .push_i      (fifo_push),
      .push_addr_i (host_waddr),
      .push_data_i (host_wdata),
      .pop_i       (fifo_pop),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (wr_level)
   );

   // Host may only post writes while no swap is pending and there is room
   assign host_wready = resetn && !fifo_full && (state_q == S_IDLE);
   assign fifo_push   = host_wvalid && host_wready;

   assign scan_rdata  = ram_rdata;
   assign scan_rvalid = scan_rvalid_q;
   assign front_bank  = front_bank_q;

   // RAM port mux: scanner first, then FIFO drain; silent during reset
   always_comb begin
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      fifo_pop  = 1'b0;
      if (resetn) begin
         if (scan_req) begin
            ram_ce   = 1'b1;
            ram_addr = {front_bank_q, scan_addr};
         end else if (!fifo_empty) begin
            ram_ce    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = {~front_bank_q, head_addr};
            ram_wdata = head_data;
            fifo_pop  = 1'b1;
         end
      end
   end

   // Swap FSM next state; the bank flips on the transition into S_SWAP so
   // the new front bank and swap_done appear together
   always_comb begin
      state_d      = state_q;
      front_bank_d = front_bank_q;
      swap_done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (swap_req) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (frame_end && fifo_empty) begin
               state_d      = S_SWAP;
               front_bank_d = ~front_bank_q;
            end
         end
         S_SWAP: begin
            swap_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, bank select and read-valid registers
   always_ff @(posedge CLK_IN) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         front_bank_q  <= 1'b0;
         scan_rvalid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         front_bank_q  <= front_bank_d;
         scan_rvalid_q <= scan_req;
      end
   end

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Self-checking bench for hub75_fb_arbiter: directed scenarios followed by
// random traffic, all checked each cycle against a transaction-level model.
module tb_hub75_fb_arbiter;

   logic        clk;
   logic        resetn;
   logic        scan_req;
   logic [10:0] scan_addr;
   logic [31:0] scan_rdata;
   logic        scan_rvalid;
   logic        frame_end;
   logic        host_wvalid;
   logic        host_wready;
   logic [10:0] host_waddr;
   logic [31:0] host_wdata;
   logic        swap_req;
   logic        swap_done;
   logic        front_bank;
   logic [2:0]  wr_level;
   logic        ram_ce, ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   hub75_fb_arbiter #(
      .ADDR_BITS  (11),
      .DATA_BITS  (32),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK_IN      (clk),
      .resetn      (resetn),
      .scan_req    (scan_req),
      .scan_addr   (scan_addr),
      .scan_rdata  (scan_rdata),
      .scan_rvalid (scan_rvalid),
      .frame_end   (frame_end),
      .host_wvalid (host_wvalid),
      .host_wready (host_wready),
      .host_waddr  (host_waddr),
      .host_wdata  (host_wdata),
      .swap_req    (swap_req),
      .swap_done   (swap_done),
      .front_bank  (front_bank),
      .wr_level    (wr_level),
      .ram_ce      (ram_ce),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [11:0] a);
      if (a == 12'h040) return 32'h12345678;
      return {a, a[7:0], 12'h5A3} ^ 32'hC3C3_0F0F;
   endfunction

   // Physical single-port RAM with one-cycle synchronous read
   logic [31:0] phys_mem [4096];
   bit          written  [4096];
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) begin
            phys_mem[ram_addr] <= ram_wdata;
            written[ram_addr]  <= 1'b1;
         end else begin
            ram_rdata <= written[ram_addr] ? phys_mem[ram_addr] : init_val(ram_addr);
         end
      end
   end

   // Reference model: expected picture contents plus pending host writes
   typedef struct {
      logic [10:0] a;
      logic [31:0] d;
   } wr_t;

   logic [31:0] ref_mem [4096];
   wr_t         q[$];
   bit          m_known;
   bit          m_fb;
   bit          m_pending;
   bit          m_swapdone;
   bit          m_rvalid;
   logic [31:0] m_rdata;

   int checks;
   int errors;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      scan_req    = 1'b0;
      scan_addr   = '0;
      frame_end   = 1'b0;
      host_wvalid = 1'b0;
      host_waddr  = '0;
      host_wdata  = '0;
      swap_req    = 1'b0;
   endtask

   // One clock: check outputs against the model, then advance the model.
   // Entered and left at posedge+1 with inputs already applied.
   task automatic cycle();
      logic        exp_ce, exp_we, exp_rdy;
      logic [11:0] exp_addr;
      logic [31:0] exp_wd;
      int          qs;
      bit          nxt_rv;
      logic [31:0] nxt_rd;
      wr_t         e;
      #3;
      qs       = q.size();
      exp_ce   = 1'b0;
      exp_we   = 1'b0;
      exp_rdy  = 1'b0;
      exp_addr = '0;
      exp_wd   = '0;
      if (resetn) begin
         exp_rdy = (qs < 4) && !m_pending && !m_swapdone;
         if (scan_req) begin
            exp_ce   = 1'b1;
            exp_addr = {m_fb, scan_addr};
         end else if (qs > 0) begin
            exp_ce   = 1'b1;
            exp_we   = 1'b1;
            exp_addr = {~m_fb, q[0].a};
            exp_wd   = q[0].d;
         end
      end
      chk("ram_ce", ram_ce, exp_ce);
      chk("ram_we", ram_we, exp_we);
      if (exp_ce) chk("ram_addr", ram_addr, exp_addr);
      if (exp_we) chk("ram_wdata", ram_wdata, exp_wd);
      chk("host_wready", host_wready, exp_rdy);
      if (m_known) begin
         chk("front_bank", front_bank, m_fb);
         chk("swap_done", swap_done, m_swapdone);
         chk("scan_rvalid", scan_rvalid, m_rvalid);
         chk("wr_level", wr_level, qs);
         if (m_rvalid) chk("scan_rdata", scan_rdata, m_rdata);
      end

      if (!resetn) begin
         q.delete();
         m_known    = 1'b1;
         m_fb       = 1'b0;
         m_pending  = 1'b0;
         m_swapdone = 1'b0;
         m_rvalid   = 1'b0;
      end else begin
         nxt_rv = scan_req;
         nxt_rd = ref_mem[{m_fb, scan_addr}];
         if (!scan_req && qs > 0) begin
            e = q.pop_front();
            ref_mem[{~m_fb, e.a}] = e.d;
         end
         if (host_wvalid && exp_rdy) begin
            e.a = host_waddr;
            e.d = host_wdata;
            q.push_back(e);
         end
         if (m_swapdone) begin
            m_swapdone = 1'b0;
         end else if (m_pending) begin
            if (frame_end && qs == 0) begin
               m_fb       = ~m_fb;
               m_swapdone = 1'b1;
               m_pending  = 1'b0;
            end
         end else if (swap_req) begin
            m_pending = 1'b1;
         end
         m_rvalid = nxt_rv;
         m_rdata  = nxt_rd;
      end
      @(posedge clk);
      #1;
   endtask

   logic [10:0] cont_addr [4];

   initial begin
      checks    = 0;
      errors    = 0;
      m_known   = 1'b0;
      m_fb      = 1'b0;
      m_pending = 1'b0;
      m_swapdone = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
      idle();
      resetn = 1'b0;
      @(posedge clk);
      #1;

      // Reset held 3 cycles with a scanner request pending
      scan_req = 1'b1;
      repeat (3) cycle();
      chk("rst_front_bank", front_bank, 1'b0);
      chk("rst_wr_level", wr_level, 3'd0);
      resetn = 1'b1;
      idle();
      #1;
      chk("wready_after_rst", host_wready, 1'b1);
      cycle();

      // Read path
      scan_req  = 1'b1;
      scan_addr = 11'h040;
      #1;
      chk("rd_addr", ram_addr, 12'h040);
      cycle();
      idle();
      #1;
      chk("rd_rvalid", scan_rvalid, 1'b1);
      chk("rd_rdata", scan_rdata, 32'h12345678);
      cycle();

      // Contention: scanner busy 64 cycles while host posts 4 writes
      for (int i = 0; i < 4; i++) cont_addr[i] = 11'(11'h100 + i * 37);
      for (int i = 0; i < 64; i++) begin
         scan_req    = 1'b1;
         scan_addr   = 11'($urandom_range(0, 2047));
         host_wvalid = (i < 4);
         host_waddr  = (i < 4) ? cont_addr[i] : '0;
         host_wdata  = $urandom;
         cycle();
      end
      idle();
      #1;
      chk("cont_level_full", wr_level, 3'd4);
      chk("cont_wready_low", host_wready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_we", ram_we, 1'b1);
         chk("drain_addr", ram_addr, {1'b1, cont_addr[i]});
         cycle();
      end
      #1;
      chk("drain_level_empty", wr_level, 3'd0);

      // Swap deferred by a non-empty FIFO
      scan_req    = 1'b1;
      host_wvalid = 1'b1;
      repeat (2) begin
         host_waddr = 11'($urandom_range(0, 2047));
         host_wdata = $urandom;
         cycle();
      end
      host_wvalid = 1'b0;
      swap_req    = 1'b1;
      cycle();
      swap_req  = 1'b0;
      frame_end = 1'b1;
      cycle();
      frame_end = 1'b0;
      #1;
      chk("defer_no_swap", front_bank, 1'b0);
      scan_req = 1'b0;
      repeat (2) cycle();
      frame_end = 1'b1;
      cycle();
      frame_end = 1'b0;
      #1;
      chk("defer_swapped", front_bank, 1'b1);
      chk("defer_swap_done", swap_done, 1'b1);
      cycle();
      chk("defer_done_pulse", swap_done, 1'b0);

      // swap_req with frame_end in the same cycle, plus a redundant request
      swap_req  = 1'b1;
      frame_end = 1'b1;
      cycle();
      idle();
      cycle();
      chk("same_cycle_no_toggle", front_bank, 1'b1);
      swap_req = 1'b1;
      cycle();
      swap_req  = 1'b0;
      frame_end = 1'b1;
      cycle();
      frame_end = 1'b0;
      #1;
      chk("same_cycle_swapped", front_bank, 1'b0);
      repeat (3) cycle();
      frame_end = 1'b1;
      cycle();
      frame_end = 1'b0;
      cycle();
      chk("single_swap_only", front_bank, 1'b0);

      // One plain swap so the bank is 1 before the reset test
      swap_req = 1'b1;
      cycle();
      swap_req  = 1'b0;
      frame_end = 1'b1;
      cycle();
      frame_end = 1'b0;
      cycle();
      chk("plain_swap", front_bank, 1'b1);

      // Reset while waiting with 3 entries queued
      scan_req    = 1'b1;
      host_wvalid = 1'b1;
      repeat (3) begin
         host_waddr = 11'($urandom_range(0, 2047));
         host_wdata = $urandom;
         cycle();
      end
      host_wvalid = 1'b0;
      swap_req    = 1'b1;
      cycle();
      idle();
      resetn = 1'b0;
      cycle();
      resetn = 1'b1;
      #1;
      chk("rst_wait_front_bank", front_bank, 1'b0);
      chk("rst_wait_level", wr_level, 3'd0);
      chk("rst_wait_wready", host_wready, 1'b1);
      repeat (3) cycle();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         resetn      = ($urandom_range(0, 199) != 0);
         scan_req    = ($urandom_range(0, 99) < 65);
         scan_addr   = 11'($urandom_range(0, 2047));
         host_wvalid = ($urandom_range(0, 1) == 1);
         host_waddr  = 11'($urandom_range(0, 2047));
         host_wdata  = $urandom;
         swap_req    = ($urandom_range(0, 19) == 0);
         frame_end   = ($urandom_range(0, 15) == 0);
         cycle();
      end
      resetn = 1'b1;
      idle();
      repeat (8) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
